// File: rtl/lock_sequencer.sv
// Two-gate water lock sequencer: arbitrates outer/inner passage requests,
// levels the chamber, and times the gate-open window with vessel hold.
module lock_sequencer #(
    parameter int FILL_CYCLES  = 4,
    parameter int DRAIN_CYCLES = 3,
    parameter int OPEN_CYCLES  = 5,
    parameter int CW           = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_outer,
    input  logic req_inner,
    input  logic hold,
    output logic outer_open,
    output logic inner_open,
    output logic filling,
    output logic draining,
    output logic grant_outer,
    output logic grant_inner,
    output logic level_high,
    output logic busy
);

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        DRAIN,
        OPEN_OUT,
        OPEN_IN
    } state_t;

    localparam logic [CW-1:0] FILL_LAST  = CW'(FILL_CYCLES - 1);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_CYCLES - 1);
    localparam logic [CW-1:0] OPEN_LAST  = CW'(OPEN_CYCLES - 1);

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          ptr, ptr_nxt;
    logic          level_nxt;
    logic          go_nxt, gi_nxt;
    logic          oo_nxt, io_nxt, fi_nxt, dr_nxt, busy_nxt;
    logic          is_open;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            ptr         <= 1'b0;
            level_high  <= 1'b0;
            grant_outer <= 1'b0;
            grant_inner <= 1'b0;
            outer_open  <= 1'b0;
            inner_open  <= 1'b0;
            filling     <= 1'b0;
            draining    <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            ptr         <= ptr_nxt;
            level_high  <= level_nxt;
            grant_outer <= go_nxt;
            grant_inner <= gi_nxt;
            outer_open  <= oo_nxt;
            inner_open  <= io_nxt;
            filling     <= fi_nxt;
            draining    <= dr_nxt;
            busy        <= busy_nxt;
        end
    end

    assign is_open = (state == OPEN_OUT) || (state == OPEN_IN);

    // ptr = 0 gives the outer side priority on a tie; it flips only on a tie
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        level_nxt = level_high;
        go_nxt    = grant_outer;
        gi_nxt    = grant_inner;
        unique case (state)
            IDLE: begin
                if (req_outer && (!req_inner || !ptr)) begin
                    go_nxt    = 1'b1;
                    ptr_nxt   = req_inner ? 1'b1 : ptr;
                    state_nxt = level_high ? DRAIN : OPEN_OUT;
                end else if (req_inner) begin
                    gi_nxt    = 1'b1;
                    ptr_nxt   = req_outer ? 1'b0 : ptr;
                    state_nxt = level_high ? OPEN_IN : FILL;
                end
            end
            FILL: begin
                if (cnt == FILL_LAST) begin
                    level_nxt = 1'b1;
                    state_nxt = OPEN_IN;
                end
            end
            DRAIN: begin
                if (cnt == DRAIN_LAST) begin
                    level_nxt = 1'b0;
                    state_nxt = OPEN_OUT;
                end
            end
            OPEN_OUT, OPEN_IN: begin
                if (!hold && cnt == OPEN_LAST) begin
                    go_nxt    = 1'b0;
                    gi_nxt    = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (state_nxt != state || state == IDLE)
            cnt_nxt = '0;
        else if (is_open && hold)
            cnt_nxt = cnt;
        else
            cnt_nxt = cnt + 1'b1;
    end

    always_comb begin
        oo_nxt   = (state_nxt == OPEN_OUT);
        io_nxt   = (state_nxt == OPEN_IN);
        fi_nxt   = (state_nxt == FILL);
        dr_nxt   = (state_nxt == DRAIN);
        busy_nxt = (state_nxt != IDLE);
    end

endmodule

// File: tb/tb_lock_sequencer.sv
// Directed bench for lock_sequencer: cycle-by-cycle output vectors
// plus a per-cycle safety invariant check.
module tb_lock_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    logic req_outer, req_inner, hold;
    logic outer_open, inner_open, filling, draining;
    logic grant_outer, grant_inner, level_high, busy;

    int n_tests = 0;
    int n_fail  = 0;

    // {outer_open, inner_open, filling, draining,
    //  grant_outer, grant_inner, level_high, busy}
    localparam logic [7:0] V_IDLE_L = 8'b0000_0000;
    localparam logic [7:0] V_IDLE_H = 8'b0000_0010;
    localparam logic [7:0] V_FILL   = 8'b0010_0101;
    localparam logic [7:0] V_OPEN_I = 8'b0100_0111;
    localparam logic [7:0] V_DRAIN  = 8'b0001_1011;
    localparam logic [7:0] V_OPEN_O = 8'b1000_1001;

    lock_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_outer  (req_outer),
        .req_inner  (req_inner),
        .hold       (hold),
        .outer_open (outer_open),
        .inner_open (inner_open),
        .filling    (filling),
        .draining   (draining),
        .grant_outer(grant_outer),
        .grant_inner(grant_inner),
        .level_high (level_high),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    wire [7:0] outs = {outer_open, inner_open, filling, draining,
                       grant_outer, grant_inner, level_high, busy};

    task automatic check(input string tag, input logic [7:0] got,
                         input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got %b exp %b", tag, $time, got, exp);
        end
    endtask

    task automatic expect_cycles(input string tag, input logic [7:0] v,
                                 input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check(tag, outs, v);
        end
    endtask

    task automatic pulse_inner();
        req_inner = 1'b1;
        @(posedge clk);
        #1 req_inner = 1'b0;
    endtask

    task automatic pulse_outer();
        req_outer = 1'b1;
        @(posedge clk);
        #1 req_outer = 1'b0;
    endtask

    logic viol;
    always_comb begin
        viol = (outer_open & inner_open) | (filling & draining)
             | ((outer_open | inner_open) & (filling | draining))
             | (outer_open & level_high) | (inner_open & ~level_high)
             | (grant_outer & grant_inner);
    end

    always @(negedge clk) check("invariant", {7'b0, viol}, 8'h00);

    initial begin
        rst_n = 1'b0;
        req_outer = 1'b0;
        req_inner = 1'b0;
        hold = 1'b0;
        repeat (2) @(negedge clk);
        check("reset", outs, V_IDLE_L);
        rst_n = 1'b1;

        pulse_inner();
        expect_cycles("t1_fill", V_FILL, 4);
        expect_cycles("t1_open_in", V_OPEN_I, 5);
        expect_cycles("t1_idle", V_IDLE_H, 1);

        pulse_outer();
        expect_cycles("t2_drain", V_DRAIN, 3);
        expect_cycles("t2_open_out", V_OPEN_O, 5);
        expect_cycles("t2_idle", V_IDLE_L, 1);

        pulse_outer();
        expect_cycles("t3_open_out", V_OPEN_O, 5);
        expect_cycles("t3_idle", V_IDLE_L, 1);

        pulse_inner();
        expect_cycles("t5_fill", V_FILL, 4);
        expect_cycles("t5_open_pre", V_OPEN_I, 2);
        hold = 1'b1;
        expect_cycles("t5_open_hold", V_OPEN_I, 7);
        hold = 1'b0;
        expect_cycles("t5_open_post", V_OPEN_I, 3);
        expect_cycles("t5_idle", V_IDLE_H, 1);

        // async reset in the middle of a fill
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        pulse_inner();
        expect_cycles("t6_fill_pre", V_FILL, 2);
        #3 rst_n = 1'b0;
        #1 check("t6_async_rst", outs, V_IDLE_L);
        @(negedge clk);
        check("t6_in_rst", outs, V_IDLE_L);
        rst_n = 1'b1;
        pulse_inner();
        expect_cycles("t6_fill", V_FILL, 4);
        expect_cycles("t6_open_in", V_OPEN_I, 5);
        expect_cycles("t6_idle", V_IDLE_H, 1);

        // both requests held from reset: round robin
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        req_outer = 1'b1;
        req_inner = 1'b1;
        expect_cycles("t4_open_out1", V_OPEN_O, 5);
        expect_cycles("t4_idle1", V_IDLE_L, 1);
        expect_cycles("t4_fill1", V_FILL, 4);
        expect_cycles("t4_open_in1", V_OPEN_I, 5);
        expect_cycles("t4_idle2", V_IDLE_H, 1);
        expect_cycles("t4_drain", V_DRAIN, 3);
        expect_cycles("t4_open_out2", V_OPEN_O, 5);
        expect_cycles("t4_idle3", V_IDLE_L, 1);
        expect_cycles("t4_fill2", V_FILL, 4);
        expect_cycles("t4_open_in2", V_OPEN_I, 5);
        req_outer = 1'b0;
        req_inner = 1'b0;
        expect_cycles("t4_idle4", V_IDLE_H, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
